// File: rtl/mul_iter_booth.sv
// rtl/mul_iter_booth.sv - iterative radix-4 Booth multiplier for RISC-V MUL/MULH/MULHSU/MULHU
// Optional zero-operand early out: define MUL_EARLY_OUT_EN.
module mul_iter_booth #(
    parameter int XLEN = 32,
    localparam int ITER = XLEN / 2 + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int EW = XLEN + 2;
    localparam int AW = 2 * XLEN + 4;
    localparam int CW = $clog2(ITER + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   mc;
    logic [EW:0]     mp;
    logic [AW-1:0]   acc;
    logic [1:0]      op_q;
    logic [XLEN-1:0] res_q;

    logic            a_sgn;
    logic            b_sgn;
    logic [EW-1:0]   rs1_ext;
    logic [EW-1:0]   rs2_ext;
    logic [AW-1:0]   pp;
    logic            zero_op;

    // MULH treats both operands as signed, MULHSU only rs1.
    assign a_sgn   = (op == 2'b01) || (op == 2'b10);
    assign b_sgn   = (op == 2'b01);
    assign rs1_ext = {{2{a_sgn & rs1[XLEN-1]}}, rs1};
    assign rs2_ext = {{2{b_sgn & rs2[XLEN-1]}}, rs2};

`ifdef MUL_EARLY_OUT_EN
    assign zero_op = (rs1 == '0) || (rs2 == '0);
`else
    assign zero_op = 1'b0;
`endif

    // mc is pre-shifted each iteration, so the window mp[2:0] is always the current digit.
    always_comb begin
        pp = '0;
        case (mp[2:0])
            3'b001, 3'b010: pp = mc;
            3'b011:         pp = mc << 1;
            3'b100:         pp = -(mc << 1);
            3'b101, 3'b110: pp = -mc;
            default:        pp = '0;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            mc    <= '0;
            mp    <= '0;
            acc   <= '0;
            op_q  <= '0;
            res_q <= '0;
        end else if (flush) begin
            state <= IDLE;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        mc    <= {{(AW - EW){rs1_ext[EW-1]}}, rs1_ext};
                        mp    <= {rs2_ext, 1'b0};
                        acc   <= '0;
                        // A zero operand jumps to the final step; acc stays 0.
                        cnt   <= zero_op ? CW'(ITER) : '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != CW'(ITER)) begin
                        acc <= acc + pp;
                        mc  <= mc << 2;
                        mp  <= mp >> 2;
                        cnt <= cnt + 1'b1;
                    end else begin
                        res_q <= (op_q == 2'b00) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter_booth.sv
// tb/tb_mul_iter_booth.sv - directed self-checking bench for mul_iter_booth
module tb_mul_iter_booth;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_fails  = 0;

    mul_iter_booth #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Issue one request with out_ready=1, return result, latency and whether in_ready stayed low.
    task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          output logic [XLEN-1:0] res, output int lat, output bit busy_ok);
        busy_ok  = 1'b1;
        lat      = 0;
        res      = 'x;
        op       = o;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op  = ~o;
        rs1 = 32'hA5A5_5A5A;
        rs2 = 32'h3C3C_C3C3;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) begin
                res = result;
                break;
            end
            if (in_ready) busy_ok = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
            n_fails++;
            $display("FAIL reset: in_ready=%b out_valid=%b result=%h, want 1 0 0", in_ready, out_valid, result);
        end
    endtask

    task automatic test_all_ones();
        logic [XLEN-1:0] r;
        int lat;
        bit bz;
        logic [XLEN-1:0] exp_r [4] = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        for (int k = 0; k < 4; k++) begin
            run_op(2'(k), 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bz);
            n_checks++;
            if (r !== exp_r[k]) begin
                n_fails++;
                $display("FAIL ones_op%0d: result=%h, want %h", k, r, exp_r[k]);
            end
            if (k == 0) begin
                n_checks++;
                if (lat !== 18) begin
                    n_fails++;
                    $display("FAIL latency: %0d cycles, want 18", lat);
                end
                n_checks++;
                if (!bz) begin
                    n_fails++;
                    $display("FAIL in_ready_busy: in_ready seen high while busy, want 0");
                end
            end
        end
    endtask

    task automatic test_boundaries();
        logic [XLEN-1:0] r;
        int lat;
        bit bz;
        logic [1:0]      vo [5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
        logic [XLEN-1:0] va [5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFE};
        logic [XLEN-1:0] vb [5] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0003};
        logic [XLEN-1:0] ve [5] = '{32'h4000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        for (int k = 0; k < 5; k++) begin
            run_op(vo[k], va[k], vb[k], r, lat, bz);
            n_checks++;
            if (r !== ve[k]) begin
                n_fails++;
                $display("FAIL boundary%0d: result=%h, want %h", k, r, ve[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] held;
        bit seen;
        bit stable;
        seen = 1'b0;
        stable = 1'b1;
        op = 2'b11; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            seen = out_valid;
        end
        held = result;
        n_checks++;
        if (!seen || held !== 32'h0B00_EA4E) begin
            n_fails++;
            $display("FAIL mulhu_hold: out_valid=%b result=%h, want 1 0b00ea4e", seen, held);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== 32'h0B00_EA4E) stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin
            n_fails++;
            $display("FAIL hold_stable: out_valid=%b result=%h, want 1 0b00ea4e", out_valid, result);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] r;
        int lat;
        bit bz;
        bit leak;
        leak = 1'b0;
        op = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        // flush still high: this request must be refused
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL flush_refuse: in_ready=%b, want 1", in_ready);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) leak = 1'b1;
        end
        n_checks++;
        if (leak) begin
            n_fails++;
            $display("FAIL flush_drop: out_valid=1 after flush, want 0");
        end
        run_op(2'b00, 32'd7, 32'd6, r, lat, bz);
        n_checks++;
        if (r !== 32'd42) begin
            n_fails++;
            $display("FAIL after_flush: result=%0d, want 42", r);
        end
    endtask

    task automatic test_async_reset();
        logic [XLEN-1:0] r;
        int lat;
        bit bz;
        op = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
            n_fails++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b result=%h, want 1 0 0", in_ready, out_valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b00, 32'd7, 32'd6, r, lat, bz);
        n_checks++;
        if (r !== 32'd42) begin
            n_fails++;
            $display("FAIL after_reset: result=%0d, want 42", r);
        end
    endtask

    task automatic test_zero_operand();
        logic [XLEN-1:0] r;
        int lat;
        bit bz;
        run_op(2'b00, 32'd0, 32'hDEAD_BEEF, r, lat, bz);
        n_checks++;
        if (r !== '0) begin
            n_fails++;
            $display("FAIL zero_result: result=%h, want 0", r);
        end
        n_checks++;
`ifdef MUL_EARLY_OUT_EN
        if (lat !== 1) begin
            n_fails++;
            $display("FAIL zero_latency: %0d cycles, want 1", lat);
        end
`else
        if (lat !== 18) begin
            n_fails++;
            $display("FAIL zero_latency: %0d cycles, want 18", lat);
        end
`endif
    endtask

    initial begin
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_all_ones();
        test_boundaries();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_zero_operand();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
